// File: rtl/char_buffer_display.sv
// Four-character scrolling buffer driving a multiplexed active-low 7-segment display.
// Optional feature: define OVERFLOW_FLAG_EN to light digit 3's decimal point after a fifth accept.
module char_buffer_display #(
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic       clear,
    input  logic [3:0] digit_sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] char_count
);

    localparam int unsigned CODE_W  = 6;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned SLOTS   = 4;
    localparam logic [CODE_W-1:0] CODE_BLANK = CODE_W'(36);
    localparam logic [CNT_W-1:0]  BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [6:0]        SEG_OFF    = 7'b1111111;
    localparam logic [3:0]        AN_OFF     = 4'b1111;

    typedef enum logic {
        S_IDLE,
        S_BLANK
    } state_t;

    state_t                        state, state_nx;
    logic [SLOTS-1:0][CODE_W-1:0]  slots, slots_nx;
    logic [CNT_W-1:0]              cnt, cnt_nx;
    logic [2:0]                    count_nx;
    logic [1:0]                    sel_idx;
    logic                          sel_ok;

    // Active-low {g,f,e,d,c,b,a}; codes above 36 render as a dash.
    function automatic logic [6:0] glyph(input logic [CODE_W-1:0] code);
        case (code)
            6'd0:  glyph = 7'b1000000;
            6'd1:  glyph = 7'b1111001;
            6'd2:  glyph = 7'b0100100;
            6'd3:  glyph = 7'b0110000;
            6'd4:  glyph = 7'b0011001;
            6'd5:  glyph = 7'b0010010;
            6'd6:  glyph = 7'b0000010;
            6'd7:  glyph = 7'b1111000;
            6'd8:  glyph = 7'b0000000;
            6'd9:  glyph = 7'b0010000;
            6'd10: glyph = 7'b0001000;
            6'd11: glyph = 7'b0000011;
            6'd12: glyph = 7'b1000110;
            6'd13: glyph = 7'b0100001;
            6'd14: glyph = 7'b0000110;
            6'd15: glyph = 7'b0001110;
            6'd16: glyph = 7'b1000010;
            6'd17: glyph = 7'b0001001;
            6'd18: glyph = 7'b1001111;
            6'd19: glyph = 7'b1100001;
            6'd20: glyph = 7'b0001010;
            6'd21: glyph = 7'b1000111;
            6'd22: glyph = 7'b1101010;
            6'd23: glyph = 7'b0101011;
            6'd24: glyph = 7'b0100011;
            6'd25: glyph = 7'b0001100;
            6'd26: glyph = 7'b0011000;
            6'd27: glyph = 7'b0101111;
            6'd28: glyph = 7'b0010010;
            6'd29: glyph = 7'b0000111;
            6'd30: glyph = 7'b1000001;
            6'd31: glyph = 7'b1100011;
            6'd32: glyph = 7'b1010101;
            6'd33: glyph = 7'b0001001;
            6'd34: glyph = 7'b0010001;
            6'd35: glyph = 7'b0100100;
            6'd36: glyph = SEG_OFF;
            default: glyph = 7'b0111111;
        endcase
    endfunction

    // State, buffer and blank-counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            slots      <= {SLOTS{CODE_BLANK}};
            cnt        <= '0;
            char_count <= '0;
            char_ready <= 1'b1;
        end else begin
            state      <= state_nx;
            slots      <= slots_nx;
            cnt        <= cnt_nx;
            char_count <= count_nx;
            char_ready <= (state_nx == S_IDLE);
        end
    end

    // Next-state: clear wins over accept; clear in BLANK restarts the blank interval
    always_comb begin
        state_nx = state;
        slots_nx = slots;
        cnt_nx   = cnt;
        count_nx = char_count;
        case (state)
            S_IDLE: begin
                if (clear) begin
                    slots_nx = {SLOTS{CODE_BLANK}};
                    count_nx = '0;
                    state_nx = S_BLANK;
                    cnt_nx   = BLANK_LOAD;
                end else if (char_valid) begin
                    slots_nx = {slots[SLOTS-2:0], char_in};
                    count_nx = (char_count == 3'd4) ? 3'd4 : char_count + 3'd1;
                    state_nx = S_BLANK;
                    cnt_nx   = BLANK_LOAD;
                end
            end
            S_BLANK: begin
                if (clear) begin
                    slots_nx = {SLOTS{CODE_BLANK}};
                    count_nx = '0;
                    cnt_nx   = BLANK_LOAD;
                end else if (cnt == '0) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // One-cold digit select decode; anything else blanks the display
    always_comb begin
        sel_idx = 2'd0;
        sel_ok  = 1'b1;
        case (digit_sel)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    // Display outputs follow next state so blanking starts the cycle after an update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (state_nx == S_IDLE && sel_ok) begin
            an  <= digit_sel;
            seg <= glyph(slots[sel_idx]);
        end else begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic ovf, ovf_nx;

    always_comb begin
        ovf_nx = ovf;
        if (clear)
            ovf_nx = 1'b0;
        else if (state == S_IDLE && char_valid && char_count == 3'd4)
            ovf_nx = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            dp  <= 1'b1;
        end else begin
            ovf <= ovf_nx;
            dp  <= ~(ovf && state_nx == S_IDLE && sel_ok && sel_idx == 2'd3);
        end
    end
`else
    assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_char_buffer_display.sv
// Scoreboard bench for char_buffer_display: stimulus queues expected display state per cycle,
// a negedge monitor pops and compares.
module tb_char_buffer_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       clear;
    logic [3:0] digit_sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] char_count;

    char_buffer_display #(.BLANK_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear      (clear),
        .digit_sel  (digit_sel),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .char_count (char_count)
    );

    always #5 clk = ~clk;

`ifdef OVERFLOW_FLAG_EN
    localparam logic DP3_OVF = 1'b0;
`else
    localparam logic DP3_OVF = 1'b1;
`endif

    typedef struct packed {
        logic [31:0] due;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic [2:0]  cnt;
        logic        rdy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in this cycle, flag any that were skipped
    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0].due) <= cyc) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_tests++;
            if (int'(e.due) < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", nm, e.due, cyc);
            end else if (an !== e.an || seg !== e.seg || dp !== e.dp ||
                         char_count !== e.cnt || char_ready !== e.rdy) begin
                n_fail++;
                $display("FAIL %s @%0d: got an=%b seg=%b dp=%b cnt=%0d rdy=%b, expected an=%b seg=%b dp=%b cnt=%0d rdy=%b",
                         nm, cyc, an, seg, dp, char_count, char_ready,
                         e.an, e.seg, e.dp, e.cnt, e.rdy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int d, input string nm, input logic [3:0] a,
                             input logic [6:0] s, input logic p, input logic [2:0] c,
                             input logic r);
        exp_t e;
        e.due = 32'(cyc + d);
        e.an  = a;
        e.seg = s;
        e.dp  = p;
        e.cnt = c;
        e.rdy = r;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!char_ready && n < 40) begin
            tick();
            n++;
        end
        if (!char_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_ready: char_ready=%b after %0d cycles, expected 1", char_ready, n);
        end
    endtask

    // Holds char_valid through any BLANK interval until the char is taken
    task automatic send_char(input logic [5:0] c);
        char_in    = c;
        char_valid = 1'b1;
        wait_ready();
        tick();
        char_valid = 1'b0;
    endtask

    task automatic show(input logic [3:0] sel, input string nm, input logic [6:0] s,
                        input logic p, input logic [2:0] c);
        digit_sel = sel;
        expect_at(1, nm, s == 7'b1111111 && !(sel == 4'b1110 || sel == 4'b1101 ||
                  sel == 4'b1011 || sel == 4'b0111) ? 4'b1111 : sel, s, p, c, 1'b1);
        tick();
    endtask

    initial begin
        rst        = 1'b0;
        char_in    = '0;
        char_valid = 1'b0;
        clear      = 1'b0;
        digit_sel  = 4'b1110;
        repeat (2) tick();
        expect_at(0, "reset_state", 4'b1111, 7'b1111111, 1'b1, 3'd0, 1'b1);
        tick();
        rst = 1'b1;
        expect_at(0, "ready_after_rst", 4'b1111, 7'b1111111, 1'b1, 3'd0, 1'b1);
        expect_at(1, "idle_empty_d0", 4'b1110, 7'b1111111, 1'b1, 3'd0, 1'b1);
        tick();

        // First accept: four blank cycles, then digit 0 shows '1'
        send_char(6'd1);
        for (int d = 0; d < 4; d++)
            expect_at(d, "blank_window", 4'b1111, 7'b1111111, 1'b1, 3'd1, 1'b0);
        expect_at(4, "blank_end", 4'b1110, 7'b1111001, 1'b1, 3'd1, 1'b1);
        send_char(6'd0);
        send_char(6'd14);
        send_char(6'd10);
        wait_ready();
        show(4'b0111, "d3_one",  7'b1111001, 1'b1, 3'd4);
        show(4'b1011, "d2_zero", 7'b1000000, 1'b1, 3'd4);
        show(4'b1101, "d1_E",    7'b0000110, 1'b1, 3'd4);
        show(4'b1110, "d0_A",    7'b0001000, 1'b1, 3'd4);
        show(4'b1100, "sel_two_low", 7'b1111111, 1'b1, 3'd4);
        show(4'b1111, "sel_none",    7'b1111111, 1'b1, 3'd4);
        show(4'b0000, "sel_all",     7'b1111111, 1'b1, 3'd4);

        // Fifth accept drops the oldest char and may raise the overflow dp
        send_char(6'd8);
        wait_ready();
        show(4'b0111, "ovf_d3",  7'b1000000, DP3_OVF, 3'd4);
        show(4'b1011, "ovf_d2",  7'b0000110, 1'b1, 3'd4);
        show(4'b1110, "ovf_d0",  7'b0000000, 1'b1, 3'd4);
        show(4'b1101, "ovf_d1",  7'b0001000, 1'b1, 3'd4);

        // Clear beats a simultaneous char in IDLE
        char_in    = 6'd5;
        char_valid = 1'b1;
        clear      = 1'b1;
        tick();
        char_valid = 1'b0;
        clear      = 1'b0;
        expect_at(0, "clr_blank", 4'b1111, 7'b1111111, 1'b1, 3'd0, 1'b0);
        wait_ready();
        show(4'b0111, "clr_d3", 7'b1111111, 1'b1, 3'd0);
        show(4'b1110, "clr_d0", 7'b1111111, 1'b1, 3'd0);

        // Clear during BLANK restarts the interval
        send_char(6'd3);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_at(3, "clr_in_blank", 4'b1111, 7'b1111111, 1'b1, 3'd0, 1'b0);
        expect_at(4, "clr_blank_end", 4'b1110, 7'b1111111, 1'b1, 3'd0, 1'b1);
        wait_ready();
        tick();

        // Asynchronous reset in the middle of BLANK
        send_char(6'd9);
        tick();
        #2;
        rst = 1'b0;
        expect_at(0, "rst_mid_blank", 4'b1111, 7'b1111111, 1'b1, 3'd0, 1'b1);
        tick();
        rst = 1'b1;
        expect_at(1, "post_rst_d0", 4'b1110, 7'b1111111, 1'b1, 3'd0, 1'b1);
        tick();

        repeat (3) tick();
        while (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation never checked", name_q.pop_front());
            void'(exp_q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
